ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset (`RstEnable` = 1'b1).
REQ-003 SHALL have port stall, input, 6, pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled.
REQ-004 SHALL have port flush, input, 1, discard EX instruction and abort accumulation.
REQ-005 SHALL have ports ex_waddr (in, 5), ex_reg_we (in, 1), ex_alu_res (in, 32): EX destination address, write enable, ALU result.
REQ-006 SHALL have ports ex_hi_we, ex_lo_we (in, 1 each), ex_hi, ex_lo (in, 32 each): EX HI/LO write request and data.
REQ-007 SHALL have ports acc_req (in, 1), acc_sub (in, 1), acc_prod (in, 64), acc_hilo (in, 64): MADD/MSUB request, 1 = subtract, signed/unsigned product, forwarded current {HI,LO}.
REQ-008 SHALL have outputs mem_waddr (5), mem_reg_we (1), mem_alu_res (32), mem_hi_we (1), mem_lo_we (1), mem_hi (32), mem_lo (32): registered MEM-stage inputs.
REQ-009 SHALL have output stallreq (1), combinational request to stall EX and earlier stages.

Function
REQ-010 SHALL implement a 2-state FSM: ACC_IDLE, ACC_BUSY; 64-bit register hilo_temp.
REQ-011 ACC_IDLE, acc_req=1, flush=0: SHALL assert stallreq, latch hilo_temp<=acc_prod, move to ACC_BUSY.
REQ-012 ACC_BUSY: SHALL deassert stallreq; sum = acc_sub ? acc_hilo-hilo_temp : acc_hilo+hilo_temp, modulo 2^64.
REQ-013 ACC_BUSY, stall[3]=0: SHALL load mem_hi=sum[63:32], mem_lo=sum[31:0], mem_hi_we=mem_lo_we=1, other fields from EX inputs; return to ACC_IDLE.
REQ-014 ACC_BUSY, stall[3]=1 (external stall): SHALL remain in ACC_BUSY with hilo_temp held.
REQ-015 Pipeline register, stall[3]=0 and no ACC_BUSY override: SHALL copy all EX inputs to outputs next edge.
REQ-016 stall[3]=1, stall[4]=0: SHALL load a bubble (mem_waddr=`NOPRegAddr`, all we=0, data=`ZeroWord`).
REQ-017 stall[3]=1, stall[4]=1: SHALL hold all outputs.
REQ-018 Accumulation first cycle SHALL produce a bubble via REQ-016 (ctrl converts stallreq into stall[3]=1, stall[4]=0); total MADD/MSUB latency 2 cycles.
REQ-019 flush=1: SHALL load bubble, force ACC_IDLE, clear hilo_temp, deassert stallreq; flush overrides stall and acc_req.
REQ-020 stallreq SHALL be 0 whenever rst=1 or flush=1.
REQ-021 Back-to-back MADD: after ACC_BUSY completes, new acc_req in ACC_IDLE SHALL restart at REQ-011 with no extra gap.

Reset
REQ-022 rst=1 at edge: all outputs to bubble values, FSM to ACC_IDLE, hilo_temp to 0; overrides flush, stall, acc_req.
REQ-023 Reset mid-accumulation SHALL discard hilo_temp; no HI/LO write emitted.

Structure
REQ-024 RstEnable, WriteEnable/Disable, ZeroWord, NOPRegAddr, RegBus, RegAddrBus, DoubleRegBus and ACC_IDLE/ACC_BUSY encodings SHALL reside in defines.v.
REQ-025 One sub-module SHALL be used: hilo_addsub (64-bit combinational add/subtract for REQ-012); all else in ex_mem.

Verification
REQ-026 Pass-through: ex_waddr=5'd3, ex_reg_we=1, ex_alu_res=32'h1234_5678, stall=0 -> next cycle mem_* equal inputs.
REQ-027 Stall: stall=6'b001111 -> bubble loaded; stall=6'b011111 -> previous outputs held unchanged.
REQ-028 MADD: acc_hilo=64'h0000_0001_FFFF_FFFF, acc_prod=64'h1, acc_sub=0 -> cycle1 stallreq=1, bubble; cycle2 mem_hi=32'h2, mem_lo=32'h0, both we=1.
REQ-029 MSUB wrap: acc_hilo=0, acc_prod=64'h5, acc_sub=1 -> mem_hi=32'hFFFF_FFFF, mem_lo=32'hFFFF_FFFB.
REQ-030 Flush/reset mid-accumulation: flush=1 (or rst=1) in ACC_BUSY -> bubble, stallreq=0, FSM ACC_IDLE, no HI/LO write.
REQ-031 External stall in ACC_BUSY: stall=6'b011111 two cycles -> hilo_temp held, then correct sum loaded when released.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared constants, bus types and accumulator state encoding for the EX/MEM
// pipeline register.
package ex_mem_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef logic [31:0] reg_bus_t;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] dreg_bus_t;

  localparam reg_bus_t  ZeroWord   = 32'h0000_0000;
  localparam reg_addr_t NOPRegAddr = 5'd0;

  // Positions in the six-bit stall vector.
  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_BUSY = 1'b1
  } acc_state_e;

endpackage

// File: rtl/ex_mem_hilo_addsub.sv
// 64-bit wrap-around add/subtract used to finish MADD/MSUB:
// sum = sub ? a - b : a + b (modulo 2^64).
module hilo_addsub
  import ex_mem_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        sub_i,
  output logic [63:0] sum_o
);

  dreg_bus_t sum;

  always_comb begin
    sum = sub_i ? (a_i - b_i) : (a_i + b_i);
  end

  assign sum_o = sum;

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with a two-cycle MADD/MSUB accumulation FSM that
// latches the product, then folds it into the forwarded {HI,LO}.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_reg_we,
  input  logic [31:0] ex_alu_res,
  input  logic        ex_hi_we,
  input  logic        ex_lo_we,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        acc_req,
  input  logic        acc_sub,
  input  logic [63:0] acc_prod,
  input  logic [63:0] acc_hilo,
  output logic [4:0]  mem_waddr,
  output logic        mem_reg_we,
  output logic [31:0] mem_alu_res,
  output logic        mem_hi_we,
  output logic        mem_lo_we,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        stallreq,
  output logic        acc_state_o
);

  acc_state_e state_q, state_d;
  dreg_bus_t  hilo_temp_q, hilo_temp_d;

  reg_addr_t  waddr_q, waddr_d;
  logic       reg_we_q, reg_we_d;
  reg_bus_t   alu_res_q, alu_res_d;
  logic       hi_we_q, hi_we_d;
  logic       lo_we_q, lo_we_d;
  reg_bus_t   hi_q, hi_d;
  reg_bus_t   lo_q, lo_d;

  dreg_bus_t  acc_sum;

  hilo_addsub u_hilo_addsub (
    .a_i   (acc_hilo),
    .b_i   (hilo_temp_q),
    .sub_i (acc_sub),
    .sum_o (acc_sum)
  );

  // Only the first accumulation cycle asks the front of the pipe to wait.
  assign stallreq = (rst != RstEnable) && !flush &&
                    (state_q == ACC_IDLE) && acc_req;

  always_comb begin
    state_d     = state_q;
    hilo_temp_d = hilo_temp_q;
    waddr_d     = waddr_q;
    reg_we_d    = reg_we_q;
    alu_res_d   = alu_res_q;
    hi_we_d     = hi_we_q;
    lo_we_d     = lo_we_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    if (flush) begin
      state_d     = ACC_IDLE;
      hilo_temp_d = 64'd0;
      waddr_d     = NOPRegAddr;
      reg_we_d    = WriteDisable;
      alu_res_d   = ZeroWord;
      hi_we_d     = WriteDisable;
      lo_we_d     = WriteDisable;
      hi_d        = ZeroWord;
      lo_d        = ZeroWord;
    end else begin
      if (!stall[StallEx]) begin
        waddr_d   = ex_waddr;
        reg_we_d  = ex_reg_we;
        alu_res_d = ex_alu_res;
        hi_we_d   = ex_hi_we;
        lo_we_d   = ex_lo_we;
        hi_d      = ex_hi;
        lo_d      = ex_lo;
      end else if (!stall[StallMem]) begin
        waddr_d   = NOPRegAddr;
        reg_we_d  = WriteDisable;
        alu_res_d = ZeroWord;
        hi_we_d   = WriteDisable;
        lo_we_d   = WriteDisable;
        hi_d      = ZeroWord;
        lo_d      = ZeroWord;
      end

      case (state_q)
        ACC_IDLE: begin
          if (acc_req) begin
            state_d     = ACC_BUSY;
            hilo_temp_d = acc_prod;
          end
        end
        ACC_BUSY: begin
          // An external EX stall keeps the latched product until released.
          if (!stall[StallEx]) begin
            state_d = ACC_IDLE;
            hi_we_d = WriteEnable;
            lo_we_d = WriteEnable;
            hi_d    = acc_sum[63:32];
            lo_d    = acc_sum[31:0];
          end
        end
        default: begin
          state_d = ACC_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= ACC_IDLE;
      hilo_temp_q <= 64'd0;
      waddr_q     <= NOPRegAddr;
      reg_we_q    <= WriteDisable;
      alu_res_q   <= ZeroWord;
      hi_we_q     <= WriteDisable;
      lo_we_q     <= WriteDisable;
      hi_q        <= ZeroWord;
      lo_q        <= ZeroWord;
    end else begin
      state_q     <= state_d;
      hilo_temp_q <= hilo_temp_d;
      waddr_q     <= waddr_d;
      reg_we_q    <= reg_we_d;
      alu_res_q   <= alu_res_d;
      hi_we_q     <= hi_we_d;
      lo_we_q     <= lo_we_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign mem_waddr   = waddr_q;
  assign mem_reg_we  = reg_we_q;
  assign mem_alu_res = alu_res_q;
  assign mem_hi_we   = hi_we_q;
  assign mem_lo_we   = lo_we_q;
  assign mem_hi      = hi_q;
  assign mem_lo      = lo_q;
  assign acc_state_o = (state_q == ACC_BUSY);

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed scenarios plus random traffic against a model that
// tracks one pending product and the expected MEM-stage word.
module tb_ex_mem;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_waddr;
  logic        ex_reg_we;
  logic [31:0] ex_alu_res;
  logic        ex_hi_we;
  logic        ex_lo_we;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        acc_req;
  logic        acc_sub;
  logic [63:0] acc_prod;
  logic [63:0] acc_hilo;
  logic [4:0]  mem_waddr;
  logic        mem_reg_we;
  logic [31:0] mem_alu_res;
  logic        mem_hi_we;
  logic        mem_lo_we;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        stallreq;
  logic        acc_state_o;

  int checks = 0;
  int errors = 0;

  localparam logic [103:0] BUBBLE = 104'd0;

  logic [103:0] obs;
  assign obs = {mem_waddr, mem_reg_we, mem_alu_res, mem_hi_we, mem_lo_we, mem_hi, mem_lo};

  // Model: expected MEM word, plus whether a product is waiting to be added.
  logic [103:0] m_out;
  bit           m_pending;
  logic [63:0]  m_temp;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_waddr(ex_waddr), .ex_reg_we(ex_reg_we), .ex_alu_res(ex_alu_res),
    .ex_hi_we(ex_hi_we), .ex_lo_we(ex_lo_we), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .acc_req(acc_req), .acc_sub(acc_sub), .acc_prod(acc_prod), .acc_hilo(acc_hilo),
    .mem_waddr(mem_waddr), .mem_reg_we(mem_reg_we), .mem_alu_res(mem_alu_res),
    .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .stallreq(stallreq), .acc_state_o(acc_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_stallreq();
    return !rst && !flush && !m_pending && acc_req;
  endfunction

  task automatic model_step();
    logic [63:0] s;
    if (rst || flush) begin
      m_out = BUBBLE; m_pending = 0; m_temp = 64'd0;
    end else if (m_pending) begin
      if (!stall[3]) begin
        s = acc_sub ? acc_hilo - m_temp : acc_hilo + m_temp;
        m_out = {ex_waddr, ex_reg_we, ex_alu_res, 2'b11, s};
        m_pending = 0;
      end else if (!stall[4]) begin
        m_out = BUBBLE;
      end
    end else begin
      if (!stall[3]) m_out = {ex_waddr, ex_reg_we, ex_alu_res, ex_hi_we, ex_lo_we, ex_hi, ex_lo};
      else if (!stall[4]) m_out = BUBBLE;
      if (acc_req) begin m_pending = 1; m_temp = acc_prod; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ex();
    ex_waddr   = 5'($urandom_range(0, 31));
    ex_reg_we  = 1'($urandom_range(0, 1));
    ex_alu_res = $urandom;
    ex_hi_we   = 1'($urandom_range(0, 1));
    ex_lo_we   = 1'($urandom_range(0, 1));
    ex_hi      = $urandom;
    ex_lo      = $urandom;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst = 1; flush = 1'($urandom_range(0, 1)); acc_req = 1;
      stall = 6'($urandom_range(0, 63)); rand_ex();
      acc_prod = {$urandom, $urandom}; acc_hilo = {$urandom, $urandom};
      #1;
      checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %b expected 0", stallreq); end
      tick();
      checks++; if (obs !== BUBBLE) begin errors++; $display("FAIL reset_outputs got %h expected %h", obs, BUBBLE); end
      checks++; if (acc_state_o !== 1'b0) begin errors++; $display("FAIL reset_state got %b expected 0", acc_state_o); end
    end
    rst = 0; flush = 0; acc_req = 0; stall = 6'd0;
  endtask

  task automatic test_passthrough();
    stall = 6'd0; acc_req = 0; flush = 0;
    ex_waddr = 5'd3; ex_reg_we = 1; ex_alu_res = 32'h1234_5678;
    ex_hi_we = 0; ex_lo_we = 0; ex_hi = 32'd0; ex_lo = 32'd0;
    tick();
    checks++;
    if (obs !== {5'd3, 1'b1, 32'h1234_5678, 66'd0}) begin
      errors++; $display("FAIL passthrough_fixed got %h expected %h", obs, {5'd3, 1'b1, 32'h1234_5678, 66'd0});
    end
    for (int i = 0; i < 5; i++) begin
      rand_ex(); tick();
      checks++; if (obs !== m_out) begin errors++; $display("FAIL passthrough_rand got %h expected %h", obs, m_out); end
    end
  endtask

  task automatic test_stall();
    logic [103:0] prev;
    stall = 6'b001111; rand_ex(); tick();
    checks++; if (obs !== BUBBLE) begin errors++; $display("FAIL stall_bubble got %h expected %h", obs, BUBBLE); end
    stall = 6'd0; rand_ex(); tick();
    prev = {ex_waddr, ex_reg_we, ex_alu_res, ex_hi_we, ex_lo_we, ex_hi, ex_lo};
    for (int i = 0; i < 2; i++) begin
      stall = 6'b011111; rand_ex(); tick();
      checks++; if (obs !== prev) begin errors++; $display("FAIL stall_hold got %h expected %h", obs, prev); end
    end
    stall = 6'd0;
  endtask

  // One complete MADD/MSUB with the controller's stall pattern on the first cycle.
  task automatic run_acc(input logic sub, input logic [63:0] prod, input logic [63:0] hilo);
    logic [63:0] exp_sum;
    exp_sum = sub ? hilo - prod : hilo + prod;
    rst = 0; flush = 0; stall = 6'b001111; acc_req = 1; acc_sub = sub;
    acc_prod = prod; acc_hilo = hilo; rand_ex();
    #1;
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL acc_stallreq_c1 got %b expected 1", stallreq); end
    tick();
    checks++; if (obs !== BUBBLE) begin errors++; $display("FAIL acc_bubble_c1 got %h expected %h", obs, BUBBLE); end
    checks++; if (acc_state_o !== 1'b1) begin errors++; $display("FAIL acc_state_c1 got %b expected 1", acc_state_o); end
    stall = 6'd0; acc_prod = {$urandom, $urandom}; rand_ex();
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL acc_stallreq_c2 got %b expected 0", stallreq); end
    tick();
    checks++;
    if ({mem_hi_we, mem_lo_we, mem_hi, mem_lo} !== {2'b11, exp_sum}) begin
      errors++; $display("FAIL acc_result got %h expected %h", {mem_hi_we, mem_lo_we, mem_hi, mem_lo}, {2'b11, exp_sum});
    end
    checks++; if (obs !== m_out) begin errors++; $display("FAIL acc_fields got %h expected %h", obs, m_out); end
    checks++; if (acc_state_o !== 1'b0) begin errors++; $display("FAIL acc_state_c2 got %b expected 0", acc_state_o); end
    acc_req = 0;
  endtask

  task automatic test_madd();
    run_acc(1'b0, 64'h1, 64'h0000_0001_FFFF_FFFF);
    checks++;
    if ({mem_hi, mem_lo} !== 64'h0000_0002_0000_0000) begin
      errors++; $display("FAIL madd_carry got %h expected %h", {mem_hi, mem_lo}, 64'h0000_0002_0000_0000);
    end
  endtask

  task automatic test_msub_wrap();
    run_acc(1'b1, 64'h5, 64'h0);
    checks++;
    if ({mem_hi, mem_lo} !== 64'hFFFF_FFFF_FFFF_FFFB) begin
      errors++; $display("FAIL msub_wrap got %h expected %h", {mem_hi, mem_lo}, 64'hFFFF_FFFF_FFFF_FFFB);
    end
  endtask

  task automatic test_abort_mid(input bit use_rst);
    stall = 6'b001111; acc_req = 1; acc_sub = 0; flush = 0; rst = 0;
    acc_prod = {$urandom, $urandom}; acc_hilo = {$urandom, $urandom}; rand_ex();
    tick();
    if (use_rst) rst = 1; else flush = 1;
    stall = 6'b011111; rand_ex();
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL abort_stallreq got %b expected 0", stallreq); end
    tick();
    checks++; if (obs !== BUBBLE) begin errors++; $display("FAIL abort_bubble got %h expected %h", obs, BUBBLE); end
    checks++; if (acc_state_o !== 1'b0) begin errors++; $display("FAIL abort_state got %b expected 0", acc_state_o); end
    rst = 0; flush = 0; acc_req = 0; stall = 6'd0; rand_ex(); ex_hi_we = 0; ex_lo_we = 0;
    tick();
    checks++; if ({mem_hi_we, mem_lo_we} !== 2'b00) begin errors++; $display("FAIL abort_no_hilo got %b expected 00", {mem_hi_we, mem_lo_we}); end
    checks++; if (obs !== m_out) begin errors++; $display("FAIL abort_after got %h expected %h", obs, m_out); end
  endtask

  task automatic test_ext_stall_busy();
    logic [63:0] p, h, exp_sum;
    p = {$urandom, $urandom}; h = {$urandom, $urandom}; exp_sum = h + p;
    stall = 6'b001111; acc_req = 1; acc_sub = 0; acc_prod = p; acc_hilo = h; rand_ex();
    tick();
    for (int i = 0; i < 2; i++) begin
      stall = 6'b011111; acc_prod = {$urandom, $urandom}; rand_ex();
      #1;
      checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL extstall_stallreq got %b expected 0", stallreq); end
      tick();
      checks++; if (obs !== BUBBLE) begin errors++; $display("FAIL extstall_hold got %h expected %h", obs, BUBBLE); end
      checks++; if (acc_state_o !== 1'b1) begin errors++; $display("FAIL extstall_state got %b expected 1", acc_state_o); end
    end
    stall = 6'd0; rand_ex();
    tick();
    checks++;
    if ({mem_hi_we, mem_lo_we, mem_hi, mem_lo} !== {2'b11, exp_sum}) begin
      errors++; $display("FAIL extstall_sum got %h expected %h", {mem_hi_we, mem_lo_we, mem_hi, mem_lo}, {2'b11, exp_sum});
    end
    acc_req = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_acc(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: stall = 6'd0;
        1: stall = 6'b001111;
        2: stall = 6'b011111;
        default: stall = 6'($urandom_range(0, 63));
      endcase
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      acc_req = ($urandom_range(0, 3) == 0);
      acc_sub = 1'($urandom_range(0, 1));
      acc_prod = {$urandom, $urandom}; acc_hilo = {$urandom, $urandom};
      rand_ex();
      #1;
      checks++;
      if (stallreq !== exp_stallreq()) begin
        errors++; $display("FAIL rand_stallreq cycle %0d got %b expected %b", i, stallreq, exp_stallreq());
      end
      tick();
      checks++; if (obs !== m_out) begin errors++; $display("FAIL rand_outputs cycle %0d got %h expected %h", i, obs, m_out); end
      checks++;
      if (acc_state_o !== m_pending) begin
        errors++; $display("FAIL rand_state cycle %0d got %b expected %b", i, acc_state_o, m_pending);
      end
    end
    rst = 0; flush = 0; acc_req = 0; stall = 6'd0;
  endtask

  initial begin
    rst = 1; stall = 6'd0; flush = 0; acc_req = 0; acc_sub = 0;
    acc_prod = 64'd0; acc_hilo = 64'd0; rand_ex();
    m_out = BUBBLE; m_pending = 0; m_temp = 64'd0;
    tick();
    test_reset();
    test_passthrough();
    test_stall();
    test_madd();
    test_msub_wrap();
    test_abort_mid(1'b0);
    test_abort_mid(1'b1);
    test_ext_stall_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
